// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
//   addr_t        : PC / fetch address (default XLEN)
//   inst_t        : 32-bit instruction word
//   fetch_entry_t : {pc, inst} pair held in the fetch buffer
package fetch_pkg;

    localparam int XLEN       = 32;
    localparam int ILEN_BYTES = 4;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [31:0]     inst_t;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries.
//   clk, reset  : clock, synchronous active-high reset
//   push_i      : write data_i at the tail
//   pop_i       : drop the head entry (ignored when empty)
//   flush_i     : discard all entries; wins over push/pop
//   data_i      : entry to write
//   head_o      : current head entry (valid while !empty_o)
//   empty_o     : no entries
//   full_o      : DEPTH entries held
//   count_o     : number of entries held
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  entry_t                     data_i,
    output entry_t                     head_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH[CW-1:0]);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    // Storage has no reset; a push while full-with-pop reuses the slot being vacated.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i && !reset) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited
// requests to an in-order variable-latency memory, a small buffer of
// returned instructions toward decode, and redirect handling.
//   clk, reset     : clock, synchronous active-high reset
//   imem_req_*     : fetch request (valid/ready, word-aligned address)
//   imem_rsp_*     : in-order instruction responses
//   inst_v_i/rdy   : decode handshake; pc_i/inst_i carry the head entry
//   pc_v_x, pc_x   : redirect from execute (pc_x[1:0] ignored)
module fetch_queue #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_v,
    input  logic            imem_req_rdy,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_v,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_v_i,
    input  logic            inst_rdy,
    output logic [XLEN-1:0] pc_i,
    output logic [31:0]     inst_i,
    input  logic            pc_v_x,
    input  logic [XLEN-1:0] pc_x
);

    import fetch_pkg::*;

    localparam int              CW   = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] STEP = XLEN'(ILEN_BYTES);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        inst_t           inst;
    } entry_t;

    logic            reset_d_q;
    logic            reset_hold;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full;
    logic            credit_ok, req_fire, rsp_keep, pop;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      unused_pc_x_low;
    entry_t          push_entry, head_entry;

    // Requests stay off for the reset cycle(s) and one cycle after release.
    assign reset_hold = reset | reset_d_q;

    // Buffered plus in-flight may never exceed DEPTH, so every response has a slot.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH[CW:0];

    assign imem_req_v    = !reset_hold && !pc_v_x && credit_ok;
    assign imem_req_addr = fetch_pc_q;
    assign req_fire      = imem_req_v && imem_req_rdy;

    assign rsp_keep   = imem_rsp_v && (drop_q == '0);
    assign push_entry = '{pc: rsp_pc_q, inst: imem_rsp_data};

    assign inst_v_i = !fifo_empty && !pc_v_x;
    assign pop      = inst_v_i && inst_rdy;
    assign pc_i     = head_entry.pc;
    assign inst_i   = head_entry.inst;

    assign redirect_pc     = {pc_x[XLEN-1:2], 2'b00};
    assign unused_pc_x_low = pc_x[1:0];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_v);
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + STEP;
        end
        if (imem_rsp_v && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
        if (rsp_keep) begin
            rsp_pc_d = rsp_pc_q + STEP;
        end
        if (pc_v_x) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            // No request fires during a redirect, so whatever is still in
            // flight after this edge is stale; earlier drops are a subset of it.
            drop_d     = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        reset_d_q <= reset;
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rsp_keep),
        .pop_i   (pop),
        .flush_i (pc_v_x),
        .data_i  (push_entry),
        .head_o  (head_entry),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    a_rsp_without_request : assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_v && (outstanding_q == '0)));

    a_push_overflow : assert property (@(posedge clk) disable iff (reset)
        !(rsp_keep && fifo_full && !pop && !pc_v_x));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_v;
    logic        imem_req_rdy = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_v = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_v_i;
    logic        inst_rdy = 1'b1;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        pc_v_x = 1'b0;
    logic [31:0] pc_x = '0;

    int errors = 0;
    int checks = 0;

    fetch_queue #(
        .XLEN     (32),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_v    (imem_req_v),
        .imem_req_rdy  (imem_req_rdy),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_v    (imem_rsp_v),
        .imem_rsp_data (imem_rsp_data),
        .inst_v_i      (inst_v_i),
        .inst_rdy      (inst_rdy),
        .pc_i          (pc_i),
        .inst_i        (inst_i),
        .pc_v_x        (pc_v_x),
        .pc_x          (pc_x)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // ---------------- reference model ----------------
    // Every request carries the redirect/reset epoch it was issued in; a
    // response is delivered only if no redirect or reset happened since.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    req_t        mem_q[$];
    ent_t        model_q[$];
    int          epoch = 0;
    int          cyc = 0;
    int          lat = 1;
    int          rsp_pct = 100;
    int          delivered = 0;
    logic [31:0] m_req_pc = RESET_PC;
    logic        reset_last = 1'b1;

    // Memory: in order, not before the due cycle, optionally stalled.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(0, 99) < rsp_pct) begin
            imem_rsp_v    = 1'b1;
            imem_rsp_data = memf(mem_q[0].addr);
        end else begin
            imem_rsp_v    = 1'b0;
            imem_rsp_data = $urandom;
        end
    end

    always @(negedge clk) begin
        logic exp_req_v, exp_inst_v, rst_supp;
        req_t r;
        rst_supp   = reset || reset_last;
        exp_req_v  = !rst_supp && !pc_v_x && ((model_q.size() + mem_q.size()) < DEPTH);
        exp_inst_v = (model_q.size() > 0) && !pc_v_x;
        checks++;
        if (imem_req_v !== exp_req_v) begin
            errors++;
            $display("FAIL mon_req_v cyc=%0d got=%b expected=%b", cyc, imem_req_v, exp_req_v);
        end
        if (exp_req_v) begin
            checks++;
            if (imem_req_addr !== m_req_pc) begin
                errors++;
                $display("FAIL mon_req_addr cyc=%0d got=%h expected=%h", cyc, imem_req_addr, m_req_pc);
            end
        end
        checks++;
        if (inst_v_i !== exp_inst_v) begin
            errors++;
            $display("FAIL mon_inst_v cyc=%0d got=%b expected=%b", cyc, inst_v_i, exp_inst_v);
        end
        if (exp_inst_v) begin
            checks++;
            if (pc_i !== model_q[0].pc || inst_i !== model_q[0].inst) begin
                errors++;
                $display("FAIL mon_head cyc=%0d got pc=%h inst=%h expected pc=%h inst=%h",
                         cyc, pc_i, inst_i, model_q[0].pc, model_q[0].inst);
            end
        end
        if (reset) begin
            model_q.delete();
            mem_q.delete();
            epoch++;
            m_req_pc = RESET_PC;
        end else begin
            if (exp_inst_v && inst_rdy) begin
                void'(model_q.pop_front());
                delivered++;
            end
            if (imem_rsp_v && mem_q.size() > 0) begin
                r = mem_q.pop_front();
                if (r.epoch == epoch && !pc_v_x)
                    model_q.push_back('{pc: r.addr, inst: imem_rsp_data});
            end
            if (pc_v_x) begin
                model_q.delete();
                epoch++;
                m_req_pc = {pc_x[31:2], 2'b00};
            end
            if (imem_req_v && imem_req_rdy) begin
                mem_q.push_back('{addr: imem_req_addr, epoch: epoch, due: cyc + lat});
                m_req_pc = imem_req_addr + 32'd4;
            end
        end
        reset_last = reset;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        reset = 1'b1; pc_v_x = 1'b0; inst_rdy = 1'b1; imem_req_rdy = 1'b1;
        lat = 1; rsp_pct = 100;
        tick(); tick(); tick();
        @(negedge clk);
        checks++;
        if (imem_req_v !== 1'b0 || inst_v_i !== 1'b0 || imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_state req_v=%b inst_v=%b addr=%h expected 0 0 %h",
                     imem_req_v, inst_v_i, imem_req_addr, RESET_PC);
        end
        tick(); reset = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_suppress req_v=%b expected 0", imem_req_v);
        end
        tick();
        @(negedge clk);
        checks++;
        if (imem_req_v !== 1'b1 || imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req req_v=%b addr=%h expected 1 %h", imem_req_v, imem_req_addr, RESET_PC);
        end
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            exp_pc = RESET_PC + 32'(4 * i);
            @(negedge clk);
            checks++;
            if (inst_v_i !== 1'b1 || pc_i !== exp_pc || inst_i !== memf(exp_pc)) begin
                errors++;
                $display("FAIL stream[%0d] inst_v=%b pc=%h inst=%h expected 1 %h %h",
                         i, inst_v_i, pc_i, inst_i, exp_pc, memf(exp_pc));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        lat = 2;
        tick();
        inst_rdy = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        checks++;
        if (imem_req_v !== 1'b0 || inst_v_i !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_full req_v=%b inst_v=%b expected 0 1", imem_req_v, inst_v_i);
        end
        tick();
        inst_rdy = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_redirect();
        bit found;
        lat = 3;
        imem_req_rdy = 1'b0;
        repeat (8) tick();
        imem_req_rdy = 1'b1;
        tick(); tick();
        imem_req_rdy = 1'b0;
        pc_v_x = 1'b1; pc_x = 32'h200;
        @(negedge clk);
        checks++;
        if (inst_v_i !== 1'b0 || imem_req_v !== 1'b0) begin
            errors++;
            $display("FAIL redirect_cycle inst_v=%b req_v=%b expected 0 0", inst_v_i, imem_req_v);
        end
        tick();
        pc_v_x = 1'b0; imem_req_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_v !== 1'b1 || imem_req_addr !== 32'h200) begin
            errors++;
            $display("FAIL redirect_req req_v=%b addr=%h expected 1 00000200", imem_req_v, imem_req_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            @(negedge clk);
            if (inst_v_i === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redirect_timeout inst_v=%b expected 1 within 20 cycles", inst_v_i);
        end else begin
            checks++;
            if (pc_i !== 32'h200 || inst_i !== memf(32'h200)) begin
                errors++;
                $display("FAIL redirect_first pc=%h inst=%h expected 00000200 %h", pc_i, inst_i, memf(32'h200));
            end
        end
        tick();
    endtask

    task automatic test_redirect_rsp();
        bit found;
        lat = 2; inst_rdy = 1'b1; imem_req_rdy = 1'b1;
        repeat (6) tick();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (imem_rsp_v === 1'b1 && inst_v_i === 1'b1) begin
                pc_v_x = 1'b1; pc_x = 32'h300; found = 1'b1;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redirect_rsp_setup rsp_v=%b inst_v=%b expected both 1", imem_rsp_v, inst_v_i);
        end else begin
            @(negedge clk);
            checks++;
            if (inst_v_i !== 1'b0 || imem_req_v !== 1'b0) begin
                errors++;
                $display("FAIL redirect_rsp_cycle inst_v=%b req_v=%b expected 0 0", inst_v_i, imem_req_v);
            end
            tick();
            pc_v_x = 1'b0;
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (inst_v_i === 1'b1) found = 1'b1;
                else tick();
            end
            checks++;
            if (!found || pc_i !== 32'h300 || inst_i !== memf(32'h300)) begin
                errors++;
                $display("FAIL redirect_rsp_next inst_v=%b pc=%h inst=%h expected 1 00000300 %h",
                         inst_v_i, pc_i, inst_i, memf(32'h300));
            end
        end
        tick();
    endtask

    task automatic test_req_stall();
        logic [31:0] hold;
        lat = 1; inst_rdy = 1'b1; imem_req_rdy = 1'b1;
        repeat (4) tick();
        imem_req_rdy = 1'b0;
        hold = m_req_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_addr !== hold) begin
                errors++;
                $display("FAIL stall_addr[%0d] addr=%h expected %h", i, imem_req_addr, hold);
            end
            tick();
        end
        imem_req_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_v !== 1'b1 || imem_req_addr !== hold) begin
            errors++;
            $display("FAIL stall_release req_v=%b addr=%h expected 1 %h", imem_req_v, imem_req_addr, hold);
        end
        tick();
        @(negedge clk);
        checks++;
        if (imem_req_addr !== hold + 32'd4) begin
            errors++;
            $display("FAIL stall_advance addr=%h expected %h", imem_req_addr, hold + 32'd4);
        end
        repeat (6) tick();
    endtask

    task automatic test_reset_mid();
        lat = 2; inst_rdy = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_req req_v=%b expected 0", imem_req_v);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_v_i !== 1'b0 || imem_req_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_clear inst_v=%b req_v=%b expected 0 0", inst_v_i, imem_req_v);
        end
        tick();
        inst_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_v !== 1'b1 || imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_mid_restart req_v=%b addr=%h expected 1 %h", imem_req_v, imem_req_addr, RESET_PC);
        end
        repeat (10) tick();
    endtask

    task automatic test_wrap();
        bit found;
        lat = 1; inst_rdy = 1'b1; imem_req_rdy = 1'b1;
        repeat (5) tick();
        pc_v_x = 1'b1; pc_x = 32'h400;
        tick();
        pc_x = 32'hFFFF_FFFF;
        tick();
        pc_v_x = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_v !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req req_v=%b addr=%h expected 1 fffffffc", imem_req_v, imem_req_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            @(negedge clk);
            if (inst_v_i === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || pc_i !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first inst_v=%b pc=%h expected 1 fffffffc", inst_v_i, pc_i);
        end
        tick();
        @(negedge clk);
        checks++;
        if (inst_v_i !== 1'b1 || pc_i !== 32'h0 || inst_i !== memf(32'h0)) begin
            errors++;
            $display("FAIL wrap_zero inst_v=%b pc=%h inst=%h expected 1 00000000 %h",
                     inst_v_i, pc_i, inst_i, memf(32'h0));
        end
        tick();
    endtask

    task automatic test_random();
        int start, r;
        start = delivered;
        for (int i = 0; i < 1500; i++) begin
            tick();
            reset = 1'b0;
            pc_v_x = 1'b0;
            inst_rdy = ($urandom_range(0, 3) != 0);
            imem_req_rdy = ($urandom_range(0, 9) < 7);
            lat = $urandom_range(1, 4);
            rsp_pct = 60;
            r = $urandom_range(0, 199);
            if (r < 2) begin
                reset = 1'b1;
            end else if (r < 8) begin
                pc_v_x = 1'b1;
                pc_x = $urandom;
            end
        end
        tick();
        reset = 1'b0; pc_v_x = 1'b0; inst_rdy = 1'b1; imem_req_rdy = 1'b1; rsp_pct = 100;
        repeat (10) tick();
        checks++;
        if (delivered - start < 100) begin
            errors++;
            $display("FAIL random_progress delivered=%0d expected at least 100", delivered - start);
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_redirect();
        test_redirect_rsp();
        test_req_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
